// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator with an internal pixel-clock divider.
// Produces registered sync/blank/enable, pixel coordinates and line/frame strobes.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int PIX_DIV  = 1,
    parameter int XW       = 11,
    parameter int YW       = 10
) (
    input  logic          CLK,
    input  logic          RST,
    output logic          pix_tick,
    output logic          HS,
    output logic          VS,
    output logic          de,
    output logic          blank,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          line_start,
    output logic          frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DW      = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

    localparam logic [DW-1:0] L_D_LAST = DW'(PIX_DIV - 1);
    localparam logic [XW-1:0] L_H_LAST = XW'(H_TOTAL - 1);
    localparam logic [XW-1:0] L_H_ACT  = XW'(H_ACTIVE);
    localparam logic [XW-1:0] L_HS_BEG = XW'(H_ACTIVE + H_FP);
    localparam logic [XW-1:0] L_HS_END = XW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [YW-1:0] L_V_LAST = YW'(V_TOTAL - 1);
    localparam logic [YW-1:0] L_V_ACT  = YW'(V_ACTIVE);
    localparam logic [YW-1:0] L_VS_BEG = YW'(V_ACTIVE + V_FP);
    localparam logic [YW-1:0] L_VS_END = YW'(V_ACTIVE + V_FP + V_SYNC);

    if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 || PIX_DIV < 1) begin : g_bad_timing
        $error("vga_timing_gen: all timing values and PIX_DIV must be >= 1");
    end
    if ((H_TOTAL - 1) >= (1 << XW) || (V_TOTAL - 1) >= (1 << YW)) begin : g_bad_width
        $error("vga_timing_gen: XW/YW too narrow for H_TOTAL/V_TOTAL");
    end

    logic [DW-1:0] r_d;
    logic [XW-1:0] r_h;
    logic [YW-1:0] r_v;
    logic          r_hs;
    logic          r_vs;
    logic          r_de;
    logic          r_blank;
    logic          r_ls;
    logic          r_fs;

    logic          w_tick;
    logic          w_h_wrap;
    logic          w_v_wrap;
    logic [XW-1:0] w_h_nxt;
    logic [YW-1:0] w_v_nxt;

    // Next-position logic; registered outputs are derived from the new (h,v).
    always_comb begin
        w_tick   = (r_d == L_D_LAST) & ~RST;
        w_h_wrap = (r_h == L_H_LAST);
        w_v_wrap = (r_v == L_V_LAST);
        if (w_h_wrap) begin
            w_h_nxt = '0;
        end else begin
            w_h_nxt = r_h + XW'(1);
        end
        if (!w_h_wrap) begin
            w_v_nxt = r_v;
        end else if (w_v_wrap) begin
            w_v_nxt = '0;
        end else begin
            w_v_nxt = r_v + YW'(1);
        end
    end

    // Divider, counters and all timing outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_d     <= '0;
            r_h     <= '0;
            r_v     <= '0;
            r_hs    <= ~HS_POL;
            r_vs    <= ~VS_POL;
            r_de    <= 1'b1;
            r_blank <= 1'b0;
            r_ls    <= 1'b0;
            r_fs    <= 1'b0;
        end else if (w_tick) begin
            r_d     <= '0;
            r_h     <= w_h_nxt;
            r_v     <= w_v_nxt;
            r_hs    <= ((w_h_nxt >= L_HS_BEG) && (w_h_nxt < L_HS_END)) ? HS_POL : ~HS_POL;
            r_vs    <= ((w_v_nxt >= L_VS_BEG) && (w_v_nxt < L_VS_END)) ? VS_POL : ~VS_POL;
            r_de    <= (w_h_nxt < L_H_ACT) && (w_v_nxt < L_V_ACT);
            r_blank <= ~((w_h_nxt < L_H_ACT) && (w_v_nxt < L_V_ACT));
            r_ls    <= w_h_wrap;
            r_fs    <= w_h_wrap & w_v_wrap;
        end else begin
            // Strobes last one CLK, not one pixel period.
            r_d     <= r_d + DW'(1);
            r_ls    <= 1'b0;
            r_fs    <= 1'b0;
        end
    end

    assign pix_tick    = w_tick;
    assign HS          = r_hs;
    assign VS          = r_vs;
    assign de          = r_de;
    assign blank       = r_blank;
    assign x           = r_h;
    assign y           = r_v;
    assign line_start  = r_ls;
    assign frame_start = r_fs;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default mode, PIX_DIV=2 with positive
// sync polarity, and a tiny 8x6 mode, all sharing one clock and reset.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    logic        d_tick, d_hs, d_vs, d_de, d_blank, d_ls, d_fs;
    logic [10:0] d_x;
    logic [9:0]  d_y;
    logic        t_tick, t_hs, t_vs, t_de, t_blank, t_ls, t_fs;
    logic [10:0] t_x;
    logic [9:0]  t_y;
    logic        s_tick, s_hs, s_vs, s_de, s_blank, s_ls, s_fs;
    logic [2:0]  s_x;
    logic [2:0]  s_y;

    vga_timing_gen u_def (
        .CLK(clk), .RST(rst), .pix_tick(d_tick), .HS(d_hs), .VS(d_vs), .de(d_de),
        .blank(d_blank), .x(d_x), .y(d_y), .line_start(d_ls), .frame_start(d_fs)
    );

    vga_timing_gen #(.PIX_DIV(2), .HS_POL(1'b1), .VS_POL(1'b1)) u_div2 (
        .CLK(clk), .RST(rst), .pix_tick(t_tick), .HS(t_hs), .VS(t_vs), .de(t_de),
        .blank(t_blank), .x(t_x), .y(t_y), .line_start(t_ls), .frame_start(t_fs)
    );

    vga_timing_gen #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
                     .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
                     .XW(3), .YW(3)) u_small (
        .CLK(clk), .RST(rst), .pix_tick(s_tick), .HS(s_hs), .VS(s_vs), .de(s_de),
        .blank(s_blank), .x(s_x), .y(s_y), .line_start(s_ls), .frame_start(s_fs)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp, input int k);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s k=%0d observed=%0d expected=%0d", tag, k, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected state while RST is held (sampled with RST=1).
    task automatic check_reset();
        chk("def_rst_tick", d_tick, 0, -1);
        chk("def_rst_x", d_x, 0, -1);
        chk("def_rst_y", d_y, 0, -1);
        chk("def_rst_hs", d_hs, 1, -1);
        chk("def_rst_vs", d_vs, 1, -1);
        chk("def_rst_de", d_de, 1, -1);
        chk("def_rst_blank", d_blank, 0, -1);
        chk("def_rst_ls", d_ls, 0, -1);
        chk("def_rst_fs", d_fs, 0, -1);
        chk("div2_rst_tick", t_tick, 0, -1);
        chk("div2_rst_hs", t_hs, 0, -1);
        chk("div2_rst_vs", t_vs, 0, -1);
        chk("div2_rst_xy", {t_x, t_y}, 0, -1);
        chk("small_rst_tick", s_tick, 0, -1);
        chk("small_rst_tuple", {s_x, s_y, s_hs, s_vs, s_de, s_ls, s_fs}, {3'd0, 3'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0}, -1);
    endtask

    // Expected state k CLK edges after reset release.
    task automatic check_all(input int k);
        int h, v, kk;
        logic [31:0] e;
        // default 800x525, PIX_DIV=1, active-low syncs
        h = k % 800;
        v = (k / 800) % 525;
        chk("def_tick", d_tick, 1, k);
        chk("def_x", d_x, h, k);
        chk("def_y", d_y, v, k);
        chk("def_de", d_de, (h < 640), k);
        chk("def_blank", d_blank, !(h < 640), k);
        chk("def_hs", d_hs, !(h >= 656 && h < 752), k);
        chk("def_vs", d_vs, !(v >= 490 && v < 492), k);
        chk("def_ls", d_ls, (k > 0 && h == 0), k);
        chk("def_fs", d_fs, (k > 0 && h == 0 && v == 0), k);
        // PIX_DIV=2, active-high syncs
        kk = k / 2;
        h  = kk % 800;
        v  = (kk / 800) % 525;
        chk("div2_tick", t_tick, (k % 2), k);
        chk("div2_x", t_x, h, k);
        chk("div2_y", t_y, v, k);
        chk("div2_de", t_de, (h < 640 && v < 480), k);
        chk("div2_hs", t_hs, (h >= 656 && h < 752), k);
        chk("div2_vs", t_vs, (v >= 490 && v < 492), k);
        chk("div2_ls", t_ls, (k > 0 && (k % 1600) == 0), k);
        chk("div2_fs", t_fs, 0, k);
        // 8x6 mode: H 4/1/2/1, V 3/1/1/1
        h = k % 8;
        v = (k / 8) % 6;
        e = {h[2:0], v[2:0], !(h >= 5 && h < 7), !(v == 4), (h < 4 && v < 3),
             (k > 0 && h == 0), (k > 0 && h == 0 && v == 0)};
        chk("small_tuple", {s_x, s_y, s_hs, s_vs, s_de, s_ls, s_fs}, e, k);
        chk("small_blank", s_blank, !(h < 4 && v < 3), k);
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) step();
        check_reset();

        rst = 1'b0;
        #1;
        check_all(0);
        // 2277 edges: default at x=677 (mid-HS), small at (5,2) (mid-HS)
        for (int k = 1; k <= 2277; k++) begin
            step();
            check_all(k);
        end
        chk("def_mid_hs", d_hs, 0, 2277);
        chk("small_mid_hs", s_hs, 0, 2277);

        rst = 1'b1;
        step();
        check_reset();

        rst = 1'b0;
        #1;
        check_all(0);
        for (int k = 1; k <= 1700; k++) begin
            step();
            check_all(k);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
